// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_RETURN,
    SRC_TRAP
  } pc_src_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0080;

  // True when the low log2(instr_bytes) address bits are all zero.
  function automatic logic pc_aligned(input logic [63:0] addr, input int unsigned instr_bytes);
    logic [63:0] mask;
    mask = 64'(instr_bytes) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bus between the pipeline controller (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Enable;
  logic             Trap;
  logic             Branch_Taken;
  logic [WIDTH-1:0] Branch_Target;
  logic             Jump;
  logic [WIDTH-1:0] Jump_Target;
  logic             Call;
  logic             Return;
  logic [WIDTH-1:0] Return_Target;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlus;
  logic             Redirect;
  logic             Misaligned;
  logic             RAS_Empty;
  logic             RAS_Full;

  modport master (
    output Enable, Trap, Branch_Taken, Branch_Target, Jump, Jump_Target,
           Call, Return, Return_Target,
    input  PCResult, PCPlus, Redirect, Misaligned, RAS_Empty, RAS_Full
  );

  modport slave (
    input  Enable, Trap, Branch_Taken, Branch_Target, Jump, Jump_Target,
           Call, Return, Return_Target,
    output PCResult, PCPlus, Redirect, Misaligned, RAS_Empty, RAS_Full
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    // Simultaneous pop+push replaces the top in place; on an empty stack it is a plain push.
    if (push && pop && !empty) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects and misalignment trapping.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  pc_unit_if.slave    bus
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus, tgt, ret_tgt, trap_vec;
  logic             redirect_q, redirect_d, misaligned_q, misaligned_d;
  logic             ras_upd, ras_empty, ras_full;
  pc_src_e          src;

  assign trap_vec = WIDTH'(TRAP_VECTOR);
  assign pc_plus  = pc_q + WIDTH'(INSTR_BYTES);
  // Speculative RAS only moves on an accepted fetch that no branch overrides.
  assign ras_upd  = bus.Enable && !bus.Trap && !bus.Branch_Taken;

`ifdef PC_RAS_EN
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;

  assign ras_push = ras_upd && bus.Jump && bus.Call;
  assign ras_pop  = ras_upd && bus.Return;
  assign ret_tgt  = ras_empty ? bus.Return_Target : ras_top;

  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (Clock),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = bus.Call ^ ras_upd;
  assign ret_tgt    = bus.Return_Target;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    src = SRC_SEQ;
    if      (bus.Trap)         src = SRC_TRAP;
    else if (bus.Branch_Taken) src = SRC_BRANCH;
    else if (bus.Jump)         src = SRC_JUMP;
    else if (bus.Return)       src = SRC_RETURN;
  end

  always_comb begin
    tgt = pc_plus;
    unique case (src)
      SRC_BRANCH: tgt = bus.Branch_Target;
      SRC_JUMP:   tgt = bus.Jump_Target;
      SRC_RETURN: tgt = ret_tgt;
      SRC_TRAP:   tgt = trap_vec;
      default:    tgt = pc_plus;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    misaligned_d = 1'b0;
    if (src == SRC_TRAP) begin
      pc_d       = trap_vec;
      redirect_d = 1'b1;
    end else if (bus.Enable) begin
      if (src == SRC_SEQ) begin
        pc_d = pc_plus;
      end else if (pc_aligned(64'(tgt), INSTR_BYTES)) begin
        pc_d       = tgt;
        redirect_d = 1'b1;
      end else begin
        pc_d         = trap_vec;
        redirect_d   = 1'b1;
        misaligned_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q         <= WIDTH'(RESET_VECTOR);
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.PCPlus     = pc_plus;
  assign bus.Redirect   = redirect_q;
  assign bus.Misaligned = misaligned_q;
  assign bus.RAS_Empty  = ras_empty;
  assign bus.RAS_Full   = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a queue-based model.
module tb_pc_unit;
  logic Clock = 1'b0;
  logic Reset, Reset8;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  pc_unit_if #(.WIDTH(32)) bus32 ();
  pc_unit_if #(.WIDTH(8))  bus8 ();

  pc_unit #(.WIDTH(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .RAS_DEPTH(4))
    u_dut (.Clock(Clock), .Reset(Reset), .bus(bus32));

  pc_unit #(.WIDTH(8), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .RAS_DEPTH(4))
    u_dut8 (.Clock(Clock), .Reset(Reset8), .bus(bus8));

  // Reference model state
  logic [31:0] m_pc;
  bit          m_red, m_mis;
  logic [31:0] m_ras [$];

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle32();
    bus32.Enable = 0; bus32.Trap = 0; bus32.Branch_Taken = 0; bus32.Jump = 0;
    bus32.Call = 0; bus32.Return = 0;
    bus32.Branch_Target = '0; bus32.Jump_Target = '0; bus32.Return_Target = '0;
  endtask

  task automatic idle8();
    bus8.Enable = 0; bus8.Trap = 0; bus8.Branch_Taken = 0; bus8.Jump = 0;
    bus8.Call = 0; bus8.Return = 0;
    bus8.Branch_Target = '0; bus8.Jump_Target = '0; bus8.Return_Target = '0;
  endtask

  // Next state from the architectural rules, RAS held as a bounded queue (back = top).
  task automatic m_step();
    logic [31:0] ppc, t;
    bit take;
    if (Reset) begin
      m_pc = 32'h0; m_red = 0; m_mis = 0; m_ras.delete();
    end else if (bus32.Trap) begin
      m_pc = 32'h80; m_red = 1; m_mis = 0;
    end else if (!bus32.Enable) begin
      m_red = 0; m_mis = 0;
    end else begin
      ppc = m_pc + 32'd4;
      take = 1;
      t = ppc;
      if (bus32.Branch_Taken) t = bus32.Branch_Target;
      else if (bus32.Jump) t = bus32.Jump_Target;
      else if (bus32.Return) begin
`ifdef PC_RAS_EN
        t = (m_ras.size() > 0) ? m_ras[$] : bus32.Return_Target;
`else
        t = bus32.Return_Target;
`endif
      end else take = 0;
`ifdef PC_RAS_EN
      if (!bus32.Branch_Taken) begin
        if (bus32.Return && m_ras.size() > 0) void'(m_ras.pop_back());
        if (bus32.Jump && bus32.Call) begin
          m_ras.push_back(ppc);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
`endif
      if (!take) begin
        m_pc = ppc; m_red = 0; m_mis = 0;
      end else if (t[1:0] != 2'b00) begin
        m_pc = 32'h80; m_red = 1; m_mis = 1;
      end else begin
        m_pc = t; m_red = 1; m_mis = 0;
      end
    end
  endtask

  task automatic test_reset();
    idle32(); Reset = 1; tick(); tick();
    n_cmp++; if (bus32.PCResult !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", bus32.PCResult, 32'h0); end
    n_cmp++; if (bus32.PCPlus !== 32'h4) begin n_err++; $display("FAIL reset_pcplus got=%h exp=%h", bus32.PCPlus, 32'h4); end
    n_cmp++; if (bus32.Redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect got=%b exp=0", bus32.Redirect); end
    n_cmp++; if (bus32.Misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned got=%b exp=0", bus32.Misaligned); end
    n_cmp++; if (bus32.RAS_Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus32.RAS_Empty); end
    n_cmp++; if (bus32.RAS_Full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus32.RAS_Full); end
    Reset = 0;
  endtask

  task automatic test_sequential();
    bus32.Enable = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (bus32.PCResult !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus32.PCResult, 32'(4 * i)); end
      n_cmp++; if (bus32.Redirect !== 1'b0) begin n_err++; $display("FAIL seq_redirect[%0d] got=%b exp=0", i, bus32.Redirect); end
    end
    bus32.Enable = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus32.PCResult !== 32'd12) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus32.PCResult, 32'd12); end
      n_cmp++; if (bus32.Redirect !== 1'b0) begin n_err++; $display("FAIL stall_redirect[%0d] got=%b exp=0", i, bus32.Redirect); end
    end
    n_cmp++; if (bus32.PCPlus !== 32'd16) begin n_err++; $display("FAIL stall_pcplus got=%h exp=%h", bus32.PCPlus, 32'd16); end
  endtask

  task automatic test_priority();
    idle32();
    bus32.Trap = 1; bus32.Branch_Taken = 1; bus32.Branch_Target = 32'h100;
    bus32.Jump = 1; bus32.Jump_Target = 32'h200;
    tick();
    n_cmp++; if (bus32.PCResult !== 32'h80) begin n_err++; $display("FAIL prio_pc got=%h exp=%h", bus32.PCResult, 32'h80); end
    n_cmp++; if (bus32.Redirect !== 1'b1) begin n_err++; $display("FAIL prio_redirect got=%b exp=1", bus32.Redirect); end
    n_cmp++; if (bus32.Misaligned !== 1'b0) begin n_err++; $display("FAIL prio_misaligned got=%b exp=0", bus32.Misaligned); end
    idle32(); tick();
    n_cmp++; if (bus32.PCResult !== 32'h80) begin n_err++; $display("FAIL prio_hold_pc got=%h exp=%h", bus32.PCResult, 32'h80); end
    n_cmp++; if (bus32.Redirect !== 1'b0) begin n_err++; $display("FAIL prio_pulse got=%b exp=0", bus32.Redirect); end
  endtask

  task automatic test_misaligned();
    idle32(); bus32.Enable = 1; bus32.Branch_Taken = 1; bus32.Branch_Target = 32'h102;
    tick();
    n_cmp++; if (bus32.PCResult !== 32'h80) begin n_err++; $display("FAIL mis_pc got=%h exp=%h", bus32.PCResult, 32'h80); end
    n_cmp++; if (bus32.Redirect !== 1'b1) begin n_err++; $display("FAIL mis_redirect got=%b exp=1", bus32.Redirect); end
    n_cmp++; if (bus32.Misaligned !== 1'b1) begin n_err++; $display("FAIL mis_flag got=%b exp=1", bus32.Misaligned); end
    bus32.Branch_Taken = 0; tick();
    n_cmp++; if (bus32.PCResult !== 32'h84) begin n_err++; $display("FAIL mis_next_pc got=%h exp=%h", bus32.PCResult, 32'h84); end
    n_cmp++; if (bus32.Misaligned !== 1'b0) begin n_err++; $display("FAIL mis_pulse got=%b exp=0", bus32.Misaligned); end
  endtask

  task automatic test_wrap();
    idle8(); Reset8 = 1; tick(); Reset8 = 0;
    bus8.Enable = 1; bus8.Branch_Taken = 1; bus8.Branch_Target = 8'hFC;
    tick();
    n_cmp++; if (bus8.PCResult !== 8'hFC) begin n_err++; $display("FAIL wrap_setup_pc got=%h exp=%h", bus8.PCResult, 8'hFC); end
    n_cmp++; if (bus8.PCPlus !== 8'h00) begin n_err++; $display("FAIL wrap_pcplus got=%h exp=%h", bus8.PCPlus, 8'h00); end
    bus8.Branch_Taken = 0; tick();
    n_cmp++; if (bus8.PCResult !== 8'h00) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", bus8.PCResult, 8'h00); end
    n_cmp++; if (bus8.Redirect !== 1'b0) begin n_err++; $display("FAIL wrap_redirect got=%b exp=0", bus8.Redirect); end
    n_cmp++; if (bus8.Misaligned !== 1'b0) begin n_err++; $display("FAIL wrap_misaligned got=%b exp=0", bus8.Misaligned); end
    bus8.Trap = 1; bus8.Enable = 0; tick();
    n_cmp++; if (bus8.PCResult !== 8'h80) begin n_err++; $display("FAIL wrap_trap_pc got=%h exp=%h", bus8.PCResult, 8'h80); end
    idle8();
  endtask

  task automatic test_ras();
    idle32(); Reset = 1; tick(); Reset = 0;
    bus32.Enable = 1; bus32.Branch_Taken = 1; bus32.Branch_Target = 32'h10; tick();
    bus32.Branch_Taken = 0;
`ifdef PC_RAS_EN
    for (int k = 1; k <= 5; k++) begin
      bus32.Jump = 1; bus32.Call = 1; bus32.Jump_Target = 32'(16 * (k + 1));
      tick();
      n_cmp++; if (bus32.PCResult !== 32'(16 * (k + 1))) begin n_err++; $display("FAIL ras_call_pc[%0d] got=%h exp=%h", k, bus32.PCResult, 32'(16 * (k + 1))); end
      n_cmp++; if (bus32.RAS_Full !== (k >= 4)) begin n_err++; $display("FAIL ras_full[%0d] got=%b exp=%b", k, bus32.RAS_Full, (k >= 4)); end
    end
    bus32.Jump = 0; bus32.Call = 0; bus32.Return = 1; bus32.Return_Target = 32'h700;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (bus32.PCResult !== 32'(32'h54 - 16 * k)) begin n_err++; $display("FAIL ras_ret_pc[%0d] got=%h exp=%h", k, bus32.PCResult, 32'(32'h54 - 16 * k)); end
      n_cmp++; if (bus32.RAS_Empty !== (k == 3)) begin n_err++; $display("FAIL ras_empty[%0d] got=%b exp=%b", k, bus32.RAS_Empty, (k == 3)); end
    end
    bus32.Return_Target = 32'h300; tick();
    n_cmp++; if (bus32.PCResult !== 32'h300) begin n_err++; $display("FAIL ras_fallback_pc got=%h exp=%h", bus32.PCResult, 32'h300); end
`else
    bus32.Jump = 1; bus32.Call = 1; bus32.Jump_Target = 32'h40; tick();
    n_cmp++; if (bus32.RAS_Empty !== 1'b1) begin n_err++; $display("FAIL noras_empty got=%b exp=1", bus32.RAS_Empty); end
    n_cmp++; if (bus32.RAS_Full !== 1'b0) begin n_err++; $display("FAIL noras_full got=%b exp=0", bus32.RAS_Full); end
    bus32.Jump = 0; bus32.Call = 0; bus32.Return = 1; bus32.Return_Target = 32'h300; tick();
    n_cmp++; if (bus32.PCResult !== 32'h300) begin n_err++; $display("FAIL noras_ret_pc got=%h exp=%h", bus32.PCResult, 32'h300); end
`endif
    idle32();
  endtask

  task automatic test_reset_midstream();
    idle32(); Reset = 1; tick(); Reset = 0;
    bus32.Enable = 1; bus32.Jump = 1; bus32.Call = 1; bus32.Jump_Target = 32'h40; tick();
    bus32.Jump_Target = 32'h60; tick();
    Reset = 1; bus32.Jump_Target = 32'h200; bus32.Trap = 1; tick(); Reset = 0; bus32.Trap = 0;
    n_cmp++; if (bus32.PCResult !== 32'h0) begin n_err++; $display("FAIL midrst_pc got=%h exp=%h", bus32.PCResult, 32'h0); end
    n_cmp++; if (bus32.RAS_Empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got=%b exp=1", bus32.RAS_Empty); end
    n_cmp++; if (bus32.Redirect !== 1'b0) begin n_err++; $display("FAIL midrst_redirect got=%b exp=0", bus32.Redirect); end
    bus32.Jump = 0; bus32.Call = 0; bus32.Return = 1; bus32.Return_Target = 32'h240; tick();
    n_cmp++; if (bus32.PCResult !== 32'h240) begin n_err++; $display("FAIL midrst_ret_pc got=%h exp=%h", bus32.PCResult, 32'h240); end
    n_cmp++; if (bus32.Redirect !== 1'b1) begin n_err++; $display("FAIL midrst_ret_redirect got=%b exp=1", bus32.Redirect); end
    idle32();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0FFF;
    if ($urandom_range(0, 7) != 0) a = a & 32'hFFFF_FFFC;
    return a;
  endfunction

  task automatic test_random();
    bit exp_empty, exp_full;
    idle32(); Reset = 1; m_step(); tick(); Reset = 0;
    for (int n = 0; n < 800; n++) begin
      Reset               = ($urandom_range(0, 59) == 0);
      bus32.Trap          = ($urandom_range(0, 19) == 0);
      bus32.Enable        = ($urandom_range(0, 3) != 0);
      bus32.Branch_Taken  = ($urandom_range(0, 5) == 0);
      bus32.Jump          = ($urandom_range(0, 3) == 0);
      bus32.Call          = ($urandom_range(0, 1) == 0);
      bus32.Return        = ($urandom_range(0, 3) == 0);
      bus32.Branch_Target = rnd_addr();
      bus32.Jump_Target   = rnd_addr();
      bus32.Return_Target = rnd_addr();
      m_step();
      tick();
`ifdef PC_RAS_EN
      exp_empty = (m_ras.size() == 0);
      exp_full  = (m_ras.size() == 4);
`else
      exp_empty = 1'b1;
      exp_full  = 1'b0;
`endif
      n_cmp++; if (bus32.PCResult !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, bus32.PCResult, m_pc); end
      n_cmp++; if (bus32.PCPlus !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pcplus[%0d] got=%h exp=%h", n, bus32.PCPlus, m_pc + 32'd4); end
      n_cmp++; if (bus32.Redirect !== m_red) begin n_err++; $display("FAIL rnd_redirect[%0d] got=%b exp=%b", n, bus32.Redirect, m_red); end
      n_cmp++; if (bus32.Misaligned !== m_mis) begin n_err++; $display("FAIL rnd_misaligned[%0d] got=%b exp=%b", n, bus32.Misaligned, m_mis); end
      n_cmp++; if (bus32.RAS_Empty !== exp_empty) begin n_err++; $display("FAIL rnd_empty[%0d] got=%b exp=%b", n, bus32.RAS_Empty, exp_empty); end
      n_cmp++; if (bus32.RAS_Full !== exp_full) begin n_err++; $display("FAIL rnd_full[%0d] got=%b exp=%b", n, bus32.RAS_Full, exp_full); end
    end
    Reset = 0; idle32();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    Reset = 1; Reset8 = 1;
    idle32(); idle8();
    @(negedge Clock);
    test_reset();
    test_sequential();
    test_priority();
    test_misaligned();
    test_wrap();
    test_ras();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined processor's fetch stage. It holds the fetch address and selects the next address from sequential increment, branch, jump, return and trap redirects under a stall/enable. It flags misaligned targets and, optionally, predicts return addresses with a small return-address stack (RAS). It drives the instruction-memory address and the PC+N value carried down the pipeline.

## Interface
- WIDTH, 32: address width in bits.
- INSTR_BYTES, 4: instruction size in bytes; power of two, ≥1.
- RESET_VECTOR, 0: PCResult value after Reset.
- TRAP_VECTOR, 32'h00000080: target on Trap or misaligned redirect; truncated to WIDTH.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2; ignored without PC_RAS_EN.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  advance PC; low = stall (hold).
- Trap  in  1  force PC to TRAP_VECTOR; acts regardless of Enable.
- Branch_Taken  in  1  take Branch_Target.
- Branch_Target  in  WIDTH  branch address.
- Jump  in  1  take Jump_Target.
- Jump_Target  in  WIDTH  jump address.
- Call  in  1  qualifies Jump as a call (push return address).
- Return  in  1  take return address.
- Return_Target  in  WIDTH  architectural return address (register file).
- PCResult  out  WIDTH  current fetch address.
- PCPlus  out  WIDTH  PCResult + INSTR_BYTES, combinational.
- Redirect  out  1  registered; high the cycle after a non-sequential update.
- Misaligned  out  1  registered; high the cycle after a misaligned target was rejected.
- RAS_Empty  out  1  RAS holds no entries.
- RAS_Full  out  1  RAS holds RAS_DEPTH entries.

## Operation
- Next-PC priority, highest first: Reset > Trap > Branch_Taken > Jump > Return > sequential.
- Reset:
  - PCResult = RESET_VECTOR.
  - Redirect = 0, Misaligned = 0.
  - RAS count = 0, pointer = 0: RAS_Empty = 1, RAS_Full = 0.
- Trap:
  - PCResult ← TRAP_VECTOR and Redirect ← 1, even when Enable = 0.
  - No RAS change.
- Enable = 0 with no Trap:
  - PCResult, RAS and count held.
  - Redirect ← 0, Misaligned ← 0.
- Enable = 1, sequential: PCResult ← PCPlus, modulo 2^WIDTH. 2^WIDTH − INSTR_BYTES wraps to 0, with no flag.
- Branch_Taken, Jump or Return:
  - Selected target aligned (low log2(INSTR_BYTES) bits zero): PCResult ← target, Redirect ← 1.
  - Misaligned: PCResult ← TRAP_VECTOR, Redirect ← 1, Misaligned ← 1.
- Return target: RAS top when RAS_Empty = 0, otherwise Return_Target.
- RAS updates occur only when Enable = 1, no Trap, and no Branch_Taken:
  - Jump & Call: push PCPlus. When full, overwrite the oldest entry (pointer wraps) and the count saturates at RAS_DEPTH.
  - Return: pop; count decrements, never below 0.
  - Jump & Call & Return in the same cycle: the jump wins the PC. The RAS top is replaced by PCPlus (pop then push) and the count is unchanged; on an empty RAS it is a push only.
- Push/pop on a misaligned redirect still occur. The RAS is speculative; its state is not corrected.

## Timing
- All state updates on the rising Clock edge; no combinational path from redirect inputs to PCResult.
- Redirect latency: inputs sampled at edge N, new PCResult visible after edge N.
- Redirect and Misaligned are one-cycle pulses aligned with the new PCResult.
- Reset asserted mid-stream wins at the next edge over every other input, including Trap.
- RAS_Empty and RAS_Full are derived from the registered count and change on the edge after a push/pop.

## Configuration
- PC_RAS_EN defined:
  - RAS storage, count and pointer are built.
  - Return prefers the RAS top as described.
- PC_RAS_EN undefined:
  - No RAS storage.
  - Return always uses Return_Target.
  - Call is ignored.
  - RAS_Empty tied 1, RAS_Full tied 0.
  - All other behaviour identical.

## Structure
- Shared package (pc_pkg):
  - next-PC source enumeration (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_RETURN, SRC_TRAP).
  - default RESET_VECTOR and TRAP_VECTOR constants.
  - an alignment-check function.
- One sub-module: pc_ras, a circular LIFO with push, pop, top, empty and full, parameterised by WIDTH and RAS_DEPTH. It is instantiated only under PC_RAS_EN.

## Test plan
- Sequential run and stall:
  - Reset, then Enable = 1 for 3 cycles → PCResult 0, 4, 8, 12.
  - Enable = 0 for 2 cycles → holds 12 with Redirect = 0.
- Priority: Trap, Branch_Taken (0x100) and Jump (0x200) asserted together with Enable = 0 → PCResult = 0x80, Redirect = 1 for one cycle.
- Misaligned branch: Branch_Taken with Branch_Target = 0x102 → PCResult = 0x80, Redirect = 1, Misaligned = 1 for one cycle.
- Wrap-around:
  - WIDTH = 8, PC at 0xFC, Enable = 1 → PCResult = 0x00, Redirect = 0.
- RAS (PC_RAS_EN, depth 4):
  - Five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → RAS_Full = 1.
  - Four Returns → 0x54, 0x44, 0x34, 0x24 and RAS_Empty = 1.
  - Fifth Return with Return_Target = 0x300 → PCResult = 0x300.
- Reset mid-stream:
  - Two pushes, then Reset together with Jump → PCResult = RESET_VECTOR, RAS_Empty = 1.
  - Following Return uses Return_Target.
